jtagg_user_dr: RTL and testbench
================================

# jtagg_user_dr

Clock-domain JTAG user data register that sits directly downstream of the ECP5 JTAGG primitive: it oversamples JTCK/JTDI/JSHIFT/JUPDATE/JCEx in the system clock domain and implements capture, shift and update for one user DR (selected by `SIR 8 TDI (32)` via JCE1). On update it presents the shifted-in word plus a one-cycle valid pulse to fabric logic, and it drives JTDO1 with the previously captured status word. It replaces raw `spi_slave` capture of TDI and supplies the missing TDO response path.

## Interface
- `C_data_len`, 64: DR length in bits; legal range 8..256.
- `C_sync_stages`, 2: synchronizer depth for all JTAGG inputs; legal range 2..3.
- `clk`  in  1  system clock (25 MHz in current tops); JTCK must be ≤ clk/8.
- `rstn`  in  1  asynchronous active-low reset.
- `jtck`  in  1  JTAGG JTCK, asynchronous to `clk`.
- `jtdi`  in  1  JTAGG JTDI.
- `jshift`  in  1  JTAGG JSHIFT.
- `jupdate`  in  1  JTAGG JUPDATE.
- `jce`  in  1  JTAGG JCE1 (register selected).
- `jrstn`  in  1  JTAGG JRSTN (TAP test-logic-reset, active-low).
- `capture_data`  in  `C_data_len`  status word loaded at capture; sampled by `clk`.
- `jtdo`  out  1  to JTAGG JTDO1; equals shift-register bit 0.
- `data`  out  `C_data_len`  last accepted DR word.
- `data_valid`  out  1  one-`clk` pulse when `data` changes.
- `data_error`  out  1  one-`clk` pulse on update with wrong bit count.
- `busy`  out  1  high while a DR scan is in progress.

## Operation
- All JTAGG inputs pass through `C_sync_stages` flops, then one edge-detect flop on `jtck`; every action occurs on the `clk` cycle where synced `jtck` rises (`tck_rise`). `jtdi`, `jshift`, `jce`, `jupdate` are used in the same synced stage as `jtck`, so they are aligned.
- Priority at each `tck_rise`: synced `jrstn` low > update > capture > shift.
- States: IDLE, SHIFT.
  - IDLE, `tck_rise` with `jce`=1 and `jshift`=0 (Capture-DR): shift register <= `capture_data`, bit count <= 0, go SHIFT.
  - SHIFT, `tck_rise` with `jce`=1 and `jshift`=1: shift register <= {`jtdi`, sr[N-1:1]} (LSB first), bit count +1 saturating at `C_data_len`+1.
  - SHIFT, `tck_rise` with `jupdate`=1: if count == `C_data_len` then `data` <= shift register and pulse `data_valid`; else pulse `data_error`, `data` unchanged. Go IDLE.
  - Any state, synced `jrstn`=0: go IDLE, clear shift register and count, no pulses.
- Shift with `jce`=0 is ignored (other instruction selected). Update in IDLE is ignored.
- `busy` = (state == SHIFT).
- Count width = clog2(`C_data_len`+2); saturation makes over-long scans report `data_error`, never wrap to a false match.

## Timing
- Reset values: `jtdo`=0, `data`=0, `data_valid`=0, `data_error`=0, `busy`=0, shift register 0, state IDLE.
- JTCK rise to shift-register/`jtdo` update: `C_sync_stages`+1 `clk` cycles (3 at default = 120 ns at 25 MHz). With JTCK ≤ clk/8, `jtdo` is stable before the next JTCK falling edge, where JTAGG samples it.
- Update latency: `data` and `data_valid` change `C_sync_stages`+1 cycles after JTCK rise in Update-DR; `data_valid` and `data_error` are exactly one cycle wide and never both high.
- `rstn` deassertion mid-scan: the scan restarts only at the next Capture-DR; partial bits are lost.
- `capture_data` is sampled on the `tck_rise` cycle only; the producer holds it stable or accepts a one-cycle-old value.

## Structure
- Shared package/include `jtagg_pkg`: DR opcode constants (USER1 = 8'h32, USER2 = 8'h38), default `C_data_len`, min JTCK/clk ratio.
- Sub-module `jtagg_sync`: parameterised N-bit multi-stage synchronizer plus rising-edge detect on bit 0; instantiated once for {jtck, jtdi, jshift, jupdate, jce, jrstn}.

## Test plan
- Scan of 64 bits 0x0123_4567_89AB_CDEF with `capture_data`=0xDEAD_BEEF_0000_FFFF, JTCK = clk/8 -> `jtdo` sequence LSB-first equals 0xDEAD_BEEF_0000_FFFF; `data`=0x0123_4567_89AB_CDEF; one `data_valid` pulse.
- 63-bit scan then update -> `data_error` pulse, `data` keeps previous value, `data_valid` stays 0.
- 65-bit scan -> `data_error` (saturated count), no wrap to a valid 64-bit match.
- Scan with `jce`=0 (USER2 selected) -> no state change, `busy` stays 0, no pulses.
- `jrstn` low for two JTCK cycles mid-scan (after 30 bits) -> `busy` drops, following full 64-bit scan completes normally with correct `data`.
- `rstn` asserted asynchronously mid-scan -> all outputs 0 within the same cycle; JTCK at exactly clk/8 with random phase offset over 1000 scans -> zero mismatches.

Source files
------------

// File: rtl/jtagg_pkg.sv
// Shared constants and types for the JTAGG user data-register block.
package jtagg_pkg;

  // JTAG instruction opcodes that select the ECP5 user data registers.
  localparam logic [7:0] USER1_OPCODE = 8'h32;
  localparam logic [7:0] USER2_OPCODE = 8'h38;

  // Default DR length in bits.
  localparam int DEFAULT_DATA_LEN = 64;

  // JTCK may run at most this fraction of clk, so that the synchronised edge
  // and the jtdo update land well inside the JTCK high phase.
  localparam int MIN_CLK_PER_TCK = 8;

  // Scan state: IDLE between scans, SHIFT from Capture-DR through Update-DR.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } dr_state_e;

endpackage

// File: rtl/jtagg_user_dr_if.sv
// Bundle of JTAGG-side and fabric-side signals of the user DR.
//
// Handshake: data_valid and data_error are one-clk strobes with no
// backpressure; the consumer takes data in the cycle data_valid is high.
// data stays unchanged until the next accepted update. The two strobes are
// never high together.
interface jtagg_user_dr_if
  import jtagg_pkg::*;
#(
  parameter int C_data_len = DEFAULT_DATA_LEN
);

  // JTAGG primitive outputs (asynchronous to clk).
  logic                  jtck;
  logic                  jtdi;
  logic                  jshift;
  logic                  jupdate;
  logic                  jce;
  logic                  jrstn;
  // Status word loaded at Capture-DR.
  logic [C_data_len-1:0] capture_data;

  // Responses.
  logic                  jtdo;
  logic [C_data_len-1:0] data;
  logic                  data_valid;
  logic                  data_error;
  logic                  busy;
  dr_state_e             dbg_state;

  modport slave (
    input  jtck, jtdi, jshift, jupdate, jce, jrstn, capture_data,
    output jtdo, data, data_valid, data_error, busy, dbg_state
  );

  modport master (
    output jtck, jtdi, jshift, jupdate, jce, jrstn, capture_data,
    input  jtdo, data, data_valid, data_error, busy, dbg_state
  );

endinterface

// File: rtl/jtagg_sync.sv
// Multi-stage synchroniser for a bundle of asynchronous inputs, plus a
// rising-edge detector on bit 0. Bit 0 is the strobe (jtck); the remaining
// bits come out of the same stage so they stay aligned with the strobe.
module jtagg_sync #(
  parameter int W      = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d_i,
  output logic [W-2:0] q_o,
  output logic         rise_o
);

  logic [W-1:0] stage_q [STAGES];
  logic         edge_q;

  // Synchroniser chain and previous-value flop for the strobe bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      edge_q <= 1'b0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      edge_q <= stage_q[STAGES-1][0];
    end
  end

  assign q_o    = stage_q[STAGES-1][W-1:1];
  assign rise_o = stage_q[STAGES-1][0] & ~edge_q;

endmodule

// File: rtl/jtagg_user_dr.sv
// JTAG user data register in the clk domain: capture / shift / update of one
// DR behind the ECP5 JTAGG primitive, with the TDO response path.
module jtagg_user_dr
  import jtagg_pkg::*;
#(
  parameter int C_data_len    = DEFAULT_DATA_LEN,
  parameter int C_sync_stages = 2
) (
  input logic              clk,
  input logic              rstn,
  jtagg_user_dr_if.slave   bus
);

  // Count must hold C_data_len+1 so an over-long scan saturates above the
  // match value instead of wrapping back onto it.
  localparam int              CW       = $clog2(C_data_len + 2);
  localparam logic [CW-1:0]   CNT_FULL = CW'(C_data_len);
  localparam logic [CW-1:0]   CNT_SAT  = CW'(C_data_len + 1);

  logic [4:0] synced;
  logic       tck_rise;
  logic       s_jtdi, s_jshift, s_jupdate, s_jce, s_jrstn;

  jtagg_sync #(
    .W      (6),
    .STAGES (C_sync_stages)
  ) u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .d_i    ({bus.jrstn, bus.jce, bus.jupdate, bus.jshift, bus.jtdi, bus.jtck}),
    .q_o    (synced),
    .rise_o (tck_rise)
  );

  assign {s_jrstn, s_jce, s_jupdate, s_jshift, s_jtdi} = synced;

  dr_state_e             state_q, state_d;
  logic [C_data_len-1:0] sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [C_data_len-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  // Next state: everything happens on a synced JTCK rise, in priority order
  // TAP reset > update > capture > shift.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    if (tck_rise) begin
      if (!s_jrstn) begin
        state_d = ST_IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end else if (s_jupdate) begin
        // Update in IDLE belongs to some other scan and is ignored.
        if (state_q == ST_SHIFT) begin
          if (cnt_q == CNT_FULL) begin
            data_d  = sr_q;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end else if (s_jce) begin
        if (state_q == ST_IDLE && !s_jshift) begin
          sr_d    = bus.capture_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else if (state_q == ST_SHIFT && s_jshift) begin
          sr_d = {s_jtdi, sr_q[C_data_len-1:1]};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  assign bus.jtdo       = sr_q[0];
  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.data_error = error_q;
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_jtagg_user_dr.sv
// Bench for jtagg_user_dr: JTAG scans driven at JTCK = clk/8 with random
// phase, expected update responses queued per scan and checked by a monitor.
module tb_jtagg_user_dr;
  import jtagg_pkg::*;

  localparam int N = 64;
  localparam int S = 2;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #20 clk = ~clk;  // 25 MHz

  jtagg_user_dr_if #(.C_data_len(N)) bus ();

  jtagg_user_dr #(
    .C_data_len    (N),
    .C_sync_stages (S)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  // bit N: 1 = error strobe expected, 0 = valid strobe; bits N-1:0 = data.
  logic [N:0]   exp_q[$];
  logic [N-1:0] model_data;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  // One JTCK period (320 ns): inputs change mid-low phase, jtdo is read
  // just before the falling edge, where JTAGG would sample it.
  task automatic tck_cycle(input logic tdi, input logic sh, input logic upd,
                           input logic ce, input logic trst, output logic tdo);
    bus.jtdi    = tdi;
    bus.jshift  = sh;
    bus.jupdate = upd;
    bus.jce     = ce;
    bus.jrstn   = trst;
    #80;
    bus.jtck = 1'b1;
    #160;
    tdo = bus.jtdo;
    bus.jtck = 1'b0;
    #80;
  endtask

  // Capture plus len shift cycles; returns the jtdo samples taken after the
  // capture and after each shift (sample k should be capture bit k).
  task automatic scan_body(input int len, input logic ce, input logic [N-1:0] word,
                           input logic [N-1:0] cd, output logic [N-1:0] tdo_act);
    logic t, b;
    tdo_act = '0;
    #($urandom_range(0, 39));
    bus.capture_data = cd;
    tck_cycle(1'b0, 1'b0, 1'b0, ce, 1'b1, t);
    tdo_act[0] = t;
    check("busy_capture", N'(bus.busy), N'(ce));
    for (int i = 0; i < len; i++) begin
      b = (i < N) ? word[i] : 1'($urandom_range(0, 1));
      tck_cycle(b, 1'b1, 1'b0, ce, 1'b1, t);
      if (i + 1 < N) tdo_act[i+1] = t;
    end
  endtask

  // Full scan: capture, len shifts, exit, update, idle.
  task automatic scan(input int len, input logic ce, input logic [N-1:0] word,
                      input logic [N-1:0] cd);
    logic [N-1:0] tdo_act, mask;
    logic t;
    int nv;
    scan_body(len, ce, word, cd, tdo_act);
    tck_cycle(1'b0, 1'b0, 1'b0, ce, 1'b1, t);  // Exit1-DR
    if (ce) begin
      if (len == N) begin
        model_data = word;
        exp_q.push_back({1'b0, model_data});
      end else begin
        exp_q.push_back({1'b1, model_data});
      end
    end
    tck_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, t);  // Update-DR
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t);  // Run-Test/Idle
    check("busy_after", N'(bus.busy), '0);
    if (ce) begin
      nv   = (len + 1 < N) ? len + 1 : N;
      mask = (nv == N) ? '1 : ((N'(1) << nv) - N'(1));
      check("tdo", tdo_act & mask, cd & mask);
    end
  endtask

  function automatic logic [N-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [N:0] e;
    forever begin
      @(negedge clk);
      if (rstn && (bus.data_valid || bus.data_error)) begin
        if (bus.data_valid) check("strobe_excl", N'(bus.data_error), '0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_strobe: valid=%0b error=%0b with none expected",
                   bus.data_valid, bus.data_error);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", N'(bus.data_error), N'(e[N]));
          check("data", bus.data, e[N-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] dummy;
    logic t;
    int r;
    bus.jtck = 1'b0; bus.jtdi = 1'b0; bus.jshift = 1'b0; bus.jupdate = 1'b0;
    bus.jce = 1'b0; bus.jrstn = 1'b1; bus.capture_data = '0;
    model_data = '0;
    repeat (5) @(posedge clk);
    #5;
    check("rst_data", bus.data, '0);
    check("rst_jtdo", N'(bus.jtdo), '0);
    check("rst_busy", N'(bus.busy), '0);
    check("rst_strobes", N'({bus.data_valid, bus.data_error}), '0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);

    // Reference scan from the bring-up checklist.
    scan(N, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_FFFF);
    check("data_direct", bus.data, 64'h0123_4567_89AB_CDEF);

    // Short, long and unselected scans.
    scan(N - 1, 1'b1, rnd_word(), rnd_word());
    scan(N + 1, 1'b1, rnd_word(), rnd_word());
    scan(N, 1'b0, rnd_word(), rnd_word());
    check("data_hold", bus.data, 64'h0123_4567_89AB_CDEF);

    // TAP reset for two JTCK cycles after 30 bits, then a clean scan.
    scan_body(30, 1'b1, rnd_word(), rnd_word(), dummy);
    tck_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, t);
    check("busy_jrstn", N'(bus.busy), '0);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t);
    scan(N, 1'b1, rnd_word(), rnd_word());

    // System reset in the middle of a scan.
    scan_body(20, 1'b1, rnd_word(), 64'hFFFF_FFFF_FFFF_FFFF, dummy);
    #($urandom_range(1, 60));
    rstn = 1'b0;
    #1;
    check("arst_data", bus.data, '0);
    check("arst_busy", N'(bus.busy), '0);
    check("arst_jtdo", N'(bus.jtdo), '0);
    model_data = '0;
    #50;
    rstn = 1'b1;
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t);
    scan(N, 1'b1, rnd_word(), rnd_word());

    // Randomised scans.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        6:       scan(N - 1, 1'b1, rnd_word(), rnd_word());
        7:       scan(N + 1 + $urandom_range(0, 2), 1'b1, rnd_word(), rnd_word());
        8:       scan($urandom_range(8, N - 2), 1'b1, rnd_word(), rnd_word());
        9:       scan(N, 1'b0, rnd_word(), rnd_word());
        default: scan(N, 1'b1, rnd_word(), rnd_word());
      endcase
    end

    repeat (20) @(negedge clk);
    check("sb_drain", N'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
